// File: rtl/sprite_pkg.sv
// Shared constants and types for the player sprite animation sequencer.
package sprite_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'd80;
  localparam logic [7:0] KEY_RIGHT = 8'd79;
  localparam logic [7:0] KEY_JUMP  = 8'd44;

  localparam logic [3:0] SPR_IDLE  = 4'd0;
  localparam logic [3:0] SPR_WALK0 = 4'd1;

  // Walk index covers up to 8 frames; jump counter covers up to 32 ticks.
  localparam int unsigned IDX_W = 3;
  localparam int unsigned K_W   = 5;
  localparam int unsigned JY_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2
  } anim_state_t;

endpackage

// File: rtl/anim_counter.sv
// Tick-enabled divide-by-ANIM_DIV counter producing a modulo-WALK_FRAMES walk index.
module anim_counter
  import sprite_pkg::*;
#(
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned WALK_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt_c
);

  localparam int unsigned DIV_W = $clog2(ANIM_DIV);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

  // Clear has priority so a direction change always restarts the cycle.
  always_comb begin
    div_nxt   = div;
    idx_nxt_c = idx;
    if (clr) begin
      div_nxt   = '0;
      idx_nxt_c = '0;
    end else if (tick) begin
      if (div == DIV_W'(ANIM_DIV - 1)) begin
        div_nxt   = '0;
        idx_nxt_c = (idx == IDX_W'(WALK_FRAMES - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        div_nxt = div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= div_nxt;
      idx <= idx_nxt_c;
    end
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Per-frame player sprite sequencer: IDLE/WALK/JUMP FSM, walk-cycle index,
// facing direction and triangular jump height profile.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned WALK_FRAMES = 4,
  parameter int unsigned JUMP_FRAMES = 16,
  parameter int unsigned JUMP_STEP   = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_tick,
  input  logic [7:0]      Keycode,
  output logic [3:0]      sprite_sel,
  output logic            face_left,
  output logic            walking,
  output logic            jumping,
  output logic [JY_W-1:0] jump_y
);

  localparam logic [3:0] SPR_JUMP = SPR_WALK0 + 4'(WALK_FRAMES);

  anim_state_t      state, state_nxt;
  logic             face_nxt;
  logic [K_W-1:0]   k, k_nxt;
  logic             adv_c, clr_c;
  logic [IDX_W-1:0] walk_idx, idx_nxt_c;
  logic [3:0]       sprite_nxt;
  logic [JY_W-1:0]  lift_c, jy_nxt;
  logic             key_left, key_right, key_jump;

  assign key_left  = (Keycode == KEY_LEFT);
  assign key_right = (Keycode == KEY_RIGHT);
  assign key_jump  = (Keycode == KEY_JUMP);

  // Every tick that is not a same-direction walk step restarts the walk cycle.
  assign clr_c = frame_tick & ~adv_c;

  anim_counter #(
    .ANIM_DIV    (ANIM_DIV),
    .WALK_FRAMES (WALK_FRAMES)
  ) u_walk_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .tick      (adv_c),
    .clr       (clr_c),
    .idx       (walk_idx),
    .idx_nxt_c (idx_nxt_c)
  );

  always_comb begin
    state_nxt = state;
    face_nxt  = face_left;
    k_nxt     = k;
    adv_c     = 1'b0;
    if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (key_left) begin
            state_nxt = WALK;
            face_nxt  = 1'b1;
          end else if (key_right) begin
            state_nxt = WALK;
            face_nxt  = 1'b0;
          end else if (key_jump) begin
            state_nxt = JUMP;
            k_nxt     = '0;
          end
        end
        WALK: begin
          if (key_left) begin
            adv_c    = face_left;
            face_nxt = 1'b1;
          end else if (key_right) begin
            adv_c    = ~face_left;
            face_nxt = 1'b0;
          end else if (key_jump) begin
            state_nxt = JUMP;
            k_nxt     = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
        JUMP: begin
          if (k == K_W'(JUMP_FRAMES - 1)) begin
            state_nxt = IDLE;
            k_nxt     = '0;
          end else begin
            k_nxt = k + K_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output values for the next frame, derived from next-state so they land on the tick edge.
  always_comb begin
    sprite_nxt = SPR_IDLE;
    jy_nxt     = '0;
    lift_c     = '0;
    if (k_nxt < K_W'(JUMP_FRAMES / 2)) begin
      lift_c = JY_W'(k_nxt);
    end else begin
      lift_c = JY_W'(JUMP_FRAMES) - JY_W'(k_nxt);
    end
    unique case (state_nxt)
      WALK: sprite_nxt = SPR_WALK0 + 4'(idx_nxt_c);
      JUMP: begin
        sprite_nxt = SPR_JUMP;
        jy_nxt     = JY_W'(JUMP_STEP) * lift_c;
      end
      default: sprite_nxt = SPR_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      face_left  <= 1'b0;
      k          <= '0;
      sprite_sel <= SPR_IDLE;
      walking    <= 1'b0;
      jumping    <= 1'b0;
      jump_y     <= '0;
    end else begin
      state      <= state_nxt;
      face_left  <= face_nxt;
      k          <= k_nxt;
      sprite_sel <= sprite_nxt;
      walking    <= (state_nxt == WALK);
      jumping    <= (state_nxt == JUMP);
      jump_y     <= jy_nxt;
    end
  end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed self-checking bench for sprite_anim_ctrl at default parameters.
module tb_sprite_anim_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] Keycode;
  logic [3:0] sprite_sel;
  logic       face_left;
  logic       walking;
  logic       jumping;
  logic [5:0] jump_y;

  int errors = 0;
  int checks = 0;

  sprite_anim_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .Keycode    (Keycode),
    .sprite_sel (sprite_sel),
    .face_left  (face_left),
    .walking    (walking),
    .jumping    (jumping),
    .jump_y     (jump_y)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] spr, input logic fl,
                         input logic wk, input logic jp, input logic [5:0] jy);
    chk({tag, ".sprite_sel"}, 8'(sprite_sel), 8'(spr));
    chk({tag, ".face_left"},  8'(face_left),  8'(fl));
    chk({tag, ".walking"},    8'(walking),    8'(wk));
    chk({tag, ".jumping"},    8'(jumping),    8'(jp));
    chk({tag, ".jump_y"},     8'(jump_y),     8'(jy));
  endtask

  // One-cycle frame pulse; outputs sampled 1ns after the capturing edge.
  task automatic tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    frame_tick = 1'b0;
    Keycode    = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk_all("in_reset", 4'd0, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) tick();
    chk_all("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0, 6'd0);

    // Walk left 33 ticks: sprite 1..4 in blocks of 8, back to 1 at tick 33.
    Keycode = 8'd80;
    for (int t = 1; t <= 33; t++) begin
      tick();
      chk($sformatf("walk_left_t%0d.sprite", t), 8'(sprite_sel), 8'(1 + ((t - 1) / 8) % 4));
      if (t == 1 || t == 33) begin
        chk($sformatf("walk_left_t%0d.face", t), 8'(face_left), 8'd1);
        chk($sformatf("walk_left_t%0d.walking", t), 8'(walking), 8'd1);
      end
    end

    Keycode = 8'd0;
    tick();
    chk_all("release_left", 4'd0, 1'b1, 1'b0, 1'b0, 6'd0);

    // Right from IDLE.
    Keycode = 8'd79;
    tick();
    chk_all("walk_right_entry", 4'd1, 1'b0, 1'b1, 1'b0, 6'd0);
    Keycode = 8'd0;
    tick();
    chk_all("release_right", 4'd0, 1'b0, 1'b0, 1'b0, 6'd0);

    // Reversal after 12 left ticks.
    Keycode = 8'd80;
    repeat (12) tick();
    chk_all("left_12", 4'd2, 1'b1, 1'b1, 1'b0, 6'd0);
    Keycode = 8'd79;
    tick();
    chk_all("reverse_right", 4'd1, 1'b0, 1'b1, 1'b0, 6'd0);
    repeat (8) tick();
    chk_all("right_after_8", 4'd2, 1'b0, 1'b1, 1'b0, 6'd0);
    Keycode = 8'd0;
    tick();
    chk_all("release_after_rev", 4'd0, 1'b0, 1'b0, 1'b0, 6'd0);

    // Jump with left held during it; facing must stay right.
    Keycode = 8'd44;
    tick();
    chk_all("jump_k0", 4'd5, 1'b0, 1'b0, 1'b1, 6'd0);
    Keycode = 8'd80;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk_all($sformatf("jump_k%0d", i), 4'd5, 1'b0, 1'b0, 1'b1,
              6'(2 * ((i < 8) ? i : 16 - i)));
    end
    tick();
    chk_all("jump_end", 4'd0, 1'b0, 1'b0, 1'b0, 6'd0);
    tick();
    chk_all("walk_after_jump", 4'd1, 1'b1, 1'b1, 1'b0, 6'd0);

    // Keycode changes between ticks must be ignored.
    Keycode = 8'd79;
    repeat (4) @(posedge Clk);
    Keycode = 8'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk_all("between_ticks", 4'd1, 1'b1, 1'b1, 1'b0, 6'd0);

    // Jump entered directly from WALK keeps face_left.
    Keycode = 8'd44;
    tick();
    chk_all("jump_from_walk", 4'd5, 1'b1, 1'b0, 1'b1, 6'd0);
    Keycode = 8'd0;
    repeat (6) tick();
    chk_all("jump_k6", 4'd5, 1'b1, 1'b0, 1'b1, 6'd12);

    // Asynchronous reset between clock edges.
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    chk_all("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge Clk);
    Reset = 1'b0;
    Keycode = 8'd44;
    tick();
    chk_all("rejump_k0", 4'd5, 1'b0, 1'b0, 1'b1, 6'd0);
    Keycode = 8'd0;
    tick();
    chk_all("rejump_k1", 4'd5, 1'b0, 1'b0, 1'b1, 6'd2);

    // Reset wins over a simultaneous frame_tick.
    @(negedge Clk);
    Reset      = 1'b1;
    frame_tick = 1'b1;
    Keycode    = 8'd80;
    @(posedge Clk);
    #1;
    chk_all("reset_vs_tick", 4'd0, 1'b0, 1'b0, 1'b0, 6'd0);
    frame_tick = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    chk_all("walk_after_reset", 4'd1, 1'b1, 1'b1, 1'b0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
